calc_pot_accumulator: RTL and testbench

Downstream consumer of the 40-bit sign-extended/padded data word (24-bit sign-extended sample in bits 39:16, zeros in bits 15:0). It evaluates one MSDAP output sample as a powers-of-two filter:
- Terms are presented group by group, from u=16 down to u=1.
- Each term is added to or subtracted from a 40-bit accumulator.
- At the end of each group the accumulator is arithmetically shifted right by one.

After NUM_GROUPS groups it presents the 40-bit result with a one-cycle valid pulse.

---
 rtl/calc_pot_accumulator_pkg.sv | 20 ++
 rtl/calc_pot_accumulator_if.sv | 35 +++
 rtl/calc_add_sub40.sv | 21 ++
 rtl/calc_pot_accumulator.sv | 112 +++++++++++
 tb/tb_calc_pot_accumulator.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pot_accumulator_pkg.sv
// Shared constants and state encoding for the powers-of-two output accumulator.
// Terms are 40-bit words: a 24-bit sign-extended sample in 39:16 and zeros in 15:0.
package calc_pot_accumulator_pkg;

  localparam int DATA_W     = 40;
  localparam int NUM_GROUPS = 16;
  localparam int GCNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Arithmetic shift right by one; the sign bit is replicated into the MSB.
  function automatic logic [DATA_W-1:0] asr1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1], v[DATA_W-1:1]};
  endfunction

endpackage

// File: rtl/calc_pot_accumulator_if.sv
// Term stream into the accumulator. The upstream side drives the master
// modport and the accumulator uses the slave modport.
interface calc_pot_accumulator_if;
  import calc_pot_accumulator_pkg::*;

  // Handshake: a beat transfers on a rising clock edge where termValid and
  // termReady are both high. While termValid is high and termReady is low, the
  // upstream side holds termData/termNeg/termNull/groupEnd stable. termReady
  // does not depend on termValid.
  logic              termValid;
  logic              termReady;
  logic [DATA_W-1:0] termData;
  logic              termNeg;
  logic              termNull;
  logic              groupEnd;

  modport master (
    output termValid,
    output termData,
    output termNeg,
    output termNull,
    output groupEnd,
    input  termReady
  );

  modport slave (
    input  termValid,
    input  termData,
    input  termNeg,
    input  termNull,
    input  groupEnd,
    output termReady
  );

endinterface

// File: rtl/calc_add_sub40.sv
// Combinational add, subtract or pass-through of one term against the accumulator.
// Arithmetic is modulo 2^DATA_W; there is no saturation.
module calc_add_sub40
  import calc_pot_accumulator_pkg::*;
(
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] term_i,
  input  logic              term_neg,
  input  logic              term_null,
  output logic [DATA_W-1:0] sum_o
);

  always_comb begin
    sum_o = acc_i;
    if (!term_null) begin
      if (term_neg) sum_o = acc_i - term_i;
      else          sum_o = acc_i + term_i;
    end
  end

endmodule

// File: rtl/calc_pot_accumulator.sv
// Evaluates one output sample as a powers-of-two filter: terms are summed per
// group (u=16 down to u=1) and the accumulator is halved after every group.
module calc_pot_accumulator
  import calc_pot_accumulator_pkg::*;
(
  input  logic                   Sclk,
  input  logic                   Reset,
  input  logic                   start,
  calc_pot_accumulator_if.slave  term_if,
  output logic [DATA_W-1:0]      yOut,
  output logic                   yValid,
  output logic                   busy,
  output state_t                 dbg_state
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   y_out_q, y_out_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic                y_valid_q, y_valid_d;
  logic                busy_q, busy_d;
  logic                term_ready_q, term_ready_d;

  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   acc_shr;
  logic                accept;
  logic                last_group;

  calc_add_sub40 u_add_sub (
    .acc_i     (acc_q),
    .term_i    (term_if.termData),
    .term_neg  (term_if.termNeg),
    .term_null (term_if.termNull),
    .sum_o     (sum)
  );

  assign accept     = term_if.termValid && term_ready_q;
  assign acc_shr    = asr1(acc_q);
  assign last_group = (gcnt_q == GCNT_W'(NUM_GROUPS - 1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    gcnt_d    = gcnt_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;

    // start overrides everything else, including a term on the same beat and
    // the final shift of a sample, so an aborted sample never reports.
    if (start) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACCUM: begin
          if (accept) begin
            acc_d = sum;
            if (term_if.groupEnd) state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_d  = acc_shr;
          gcnt_d = gcnt_q + GCNT_W'(1);
          if (last_group) begin
            y_out_d   = acc_shr;
            y_valid_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d       = (state_d != ST_IDLE);
    term_ready_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      gcnt_q       <= '0;
      y_out_q      <= '0;
      y_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      term_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      gcnt_q       <= gcnt_d;
      y_out_q      <= y_out_d;
      y_valid_q    <= y_valid_d;
      busy_q       <= busy_d;
      term_ready_q <= term_ready_d;
    end
  end

  assign term_if.termReady = term_ready_q;
  assign yOut              = y_out_q;
  assign yValid            = y_valid_q;
  assign busy              = busy_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_calc_pot_accumulator.sv
// Bench for calc_pot_accumulator: directed samples plus randomized samples
// checked against a group-by-group arithmetic model of the filter.
module tb_calc_pot_accumulator;
  import calc_pot_accumulator_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              neg;
    logic              nul;
    logic              ge;
  } beat_t;

  logic              Sclk = 1'b0;
  logic              Reset;
  logic              start;
  logic [DATA_W-1:0] yOut;
  logic              yValid;
  logic              busy;
  state_t            dbg_state;

  calc_pot_accumulator_if tif ();

  calc_pot_accumulator dut (
    .Sclk      (Sclk),
    .Reset     (Reset),
    .start     (start),
    .term_if   (tif),
    .yOut      (yOut),
    .yValid    (yValid),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Sclk = ~Sclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int                checks   = 0;
  int                failures = 0;
  int                yv_count = 0;
  int                accepted = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;
  beat_t             beats[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts accepted beats and checks every result pulse against the queue.
  always @(negedge Sclk) begin
    if (!Reset && !start && tif.termValid && tif.termReady) accepted++;
    if (yValid) begin
      yv_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_yvalid: got yOut=0x%0h required no result pulse", yOut);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("yout", 64'(yOut), 64'(mon_exp));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] model_result();
    logic signed [DATA_W-1:0] acc;
    acc = '0;
    foreach (beats[i]) begin
      if (!beats[i].nul) begin
        if (beats[i].neg) acc = acc - $signed(beats[i].data);
        else              acc = acc + $signed(beats[i].data);
      end
      if (beats[i].ge) acc = acc >>> 1;
    end
    return acc;
  endfunction

  // ---------------- stimulus builders ----------------
  task automatic add_group(input logic [DATA_W-1:0] d, input logic neg);
    beats.push_back('{data: d, neg: neg, nul: 1'b0, ge: 1'b1});
  endtask

  task automatic add_empty(input int n);
    for (int i = 0; i < n; i++)
      beats.push_back('{data: 40'h0, neg: 1'b0, nul: 1'b1, ge: 1'b1});
  endtask

  task automatic add_random_sample();
    for (int g = 0; g < NUM_GROUPS; g++) begin
      int n;
      n = $urandom_range(0, 3);
      if (n == 0) add_empty(1);
      else begin
        for (int k = 0; k < n; k++) begin
          logic [23:0] s;
          beat_t b;
          s      = 24'($urandom);
          b.data = {s, 16'h0000};
          b.neg  = 1'($urandom_range(0, 1));
          b.nul  = ($urandom_range(0, 4) == 0);
          b.ge   = (k == n - 1);
          beats.push_back(b);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge Sclk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input beat_t b);
    int n;
    tif.termValid = 1'b1;
    tif.termData  = b.data;
    tif.termNeg   = b.neg;
    tif.termNull  = b.nul;
    tif.groupEnd  = b.ge;
    n = 0;
    forever begin
      @(negedge Sclk);
      if (tif.termReady) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout: got termReady=0 for 50 cycles, required 1");
        break;
      end
    end
    @(posedge Sclk); #1;
  endtask

  task automatic drive_all(input bit gaps);
    foreach (beats[i]) begin
      drive_beat(beats[i]);
      if (gaps && i != beats.size() - 1 && $urandom_range(0, 3) == 0) begin
        tif.termValid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge Sclk); #1; end
      end
    end
    tif.termValid = 1'b0;
  endtask

  // Called right after the final groupEnd beat has been accepted.
  task automatic tail_checks();
    @(negedge Sclk);
    chk("shift_cycle_yvalid", 64'(yValid), 64'd0);
    chk("shift_cycle_busy",   64'(busy),   64'd1);
    @(negedge Sclk);
    chk("t2_yvalid", 64'(yValid), 64'd1);
    chk("t2_busy",   64'(busy),   64'd0);
    @(posedge Sclk); #1;
  endtask

  task automatic do_sample(input logic [DATA_W-1:0] exp, input bit gaps);
    int acc0;
    acc0 = accepted;
    exp_q.push_back(exp);
    pulse_start();
    drive_all(gaps);
    tail_checks();
    chk("accept_count", 64'(accepted - acc0), 64'(beats.size()));
    beats.delete();
    repeat (2) @(posedge Sclk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int yv0;
    Reset         = 1'b1;
    start         = 1'b0;
    tif.termValid = 1'b0;
    tif.termData  = '0;
    tif.termNeg   = 1'b0;
    tif.termNull  = 1'b0;
    tif.groupEnd  = 1'b0;
    repeat (3) @(posedge Sclk);
    #1 Reset = 1'b0;
    @(negedge Sclk);
    chk("rst_yout",      64'(yOut),          64'd0);
    chk("rst_yvalid",    64'(yValid),        64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_ready",     64'(tif.termReady), 64'd0);
    chk("rst_state",     64'(dbg_state),     64'(ST_IDLE));
    @(posedge Sclk); #1;

    // Last-group term only.
    add_empty(15); add_group(40'h00_0001_0000, 1'b0);
    do_sample(40'h00_0000_8000, 1'b0);
    // First-group term only: sixteen halvings.
    add_group(40'h00_0001_0000, 1'b0); add_empty(15);
    do_sample(40'h00_0000_0001, 1'b1);
    // Negative term added, then subtracted.
    add_empty(15); add_group(40'hFF_FFFF_0000, 1'b0);
    do_sample(40'hFF_FFFF_8000, 1'b0);
    add_empty(15); add_group(40'hFF_FFFF_0000, 1'b1);
    do_sample(40'h00_0000_8000, 1'b0);
    // Wrap: two large positive terms overflow into the sign bit.
    add_empty(15);
    beats.push_back('{data: 40'h7F_FFFF_0000, neg: 1'b0, nul: 1'b0, ge: 1'b0});
    add_group(40'h7F_FFFF_0000, 1'b0);
    do_sample(40'hFF_FFFF_0000, 1'b0);

    // Abort: restart after five groups, with a term presented on the restart beat.
    yv0 = yv_count;
    for (int i = 0; i < 5; i++) add_group(40'h00_0010_0000, 1'b0);
    pulse_start();
    drive_all(1'b0);
    beats.delete();
    tif.termValid = 1'b1; tif.termData = 40'h12_3456_0000;
    tif.termNeg = 1'b0; tif.termNull = 1'b0; tif.groupEnd = 1'b0;
    add_empty(16);
    do_sample(40'h0, 1'b0);
    chk("abort_one_yvalid", 64'(yv_count - yv0), 64'd1);

    // Restart in the same cycle as the final shift suppresses the result.
    yv0 = yv_count;
    add_random_sample();
    pulse_start();
    drive_all(1'b0);
    beats.delete();
    pulse_start();
    @(negedge Sclk);
    chk("restart_final_shift_busy", 64'(busy), 64'd1);
    @(posedge Sclk); #1;
    add_empty(15); add_group(40'h00_0001_0000, 1'b0);
    do_sample(40'h00_0000_8000, 1'b0);
    chk("restart_one_yvalid", 64'(yv_count - yv0), 64'd1);

    // Randomized samples; the gap-free ones hold termValid across every shift.
    for (int r = 0; r < 10; r++) begin
      add_random_sample();
      do_sample(model_result(), (r % 3) != 0);
    end

    // Reset in the middle of accumulation clears the result register.
    add_empty(15); add_group(40'h00_0001_0000, 1'b0);
    do_sample(40'h00_0000_8000, 1'b0);
    for (int i = 0; i < 3; i++) add_group(40'h00_0004_0000, 1'b0);
    pulse_start();
    drive_all(1'b0);
    beats.delete();
    tif.termValid = 1'b1;
    Reset = 1'b1;
    @(posedge Sclk); #1;
    Reset = 1'b0;
    tif.termValid = 1'b0;
    @(negedge Sclk);
    chk("midrst_yout",   64'(yOut),          64'd0);
    chk("midrst_busy",   64'(busy),          64'd0);
    chk("midrst_yvalid", 64'(yValid),        64'd0);
    chk("midrst_ready",  64'(tif.termReady), 64'd0);
    repeat (4) @(posedge Sclk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
